// File: rtl/pipe_stall_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_stall_ctrl_pkg
// Description : Shared stall-vector constants, cause encodings and FSM type
//               for the pipeline stall controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_stall_ctrl_pkg;

    localparam int STALL_WIDTH = 6;
    localparam int LAT_WIDTH   = 3;

    // Stall vector bit order: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
    localparam logic [STALL_WIDTH-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_WIDTH-1:0] STALL_HAZ  = 6'b000111;
    localparam logic [STALL_WIDTH-1:0] STALL_EXH  = 6'b001111;
    localparam logic [STALL_WIDTH-1:0] STALL_MEMH = 6'b011111;

    localparam logic [2:0] CAUSE_RUN   = 3'd0;
    localparam logic [2:0] CAUSE_HAZ   = 3'd1;
    localparam logic [2:0] CAUSE_EXH   = 3'd2;
    localparam logic [2:0] CAUSE_MEMH  = 3'd3;
    localparam logic [2:0] CAUSE_FLUSH = 3'd4;

    typedef enum logic [2:0] {
        ST_RUN   = CAUSE_RUN,
        ST_HAZ   = CAUSE_HAZ,
        ST_EXH   = CAUSE_EXH,
        ST_MEMH  = CAUSE_MEMH,
        ST_FLUSH = CAUSE_FLUSH
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_stall_ctrl_reg_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register writer-latency counters with clear/hold/
//               decrement/set update, two hazard lookups and a pending mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int LAT_WIDTH      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_hold,
    input  logic                      i_set,
    input  logic [REG_ADDR_WIDTH-1:0] i_set_addr,
    input  logic [LAT_WIDTH-1:0]      i_set_lat,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr1,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr2,
    output logic                      o_busy1,
    output logic                      o_busy2,
    output logic [NUM_REGS-1:0]       o_pending_mask
);

    logic [LAT_WIDTH-1:0] r_cnt [NUM_REGS];

    // r0 is cleared with the rest but never decremented or set, so it stays 0.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else if (!i_hold) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (i_set && (i_set_addr == REG_ADDR_WIDTH'(r))) begin
                    r_cnt[r] <= i_set_lat;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - LAT_WIDTH'(1);
                end
            end
        end
    end

    assign o_busy1 = (i_rd_addr1 != '0) && (r_cnt[i_rd_addr1] != '0);
    assign o_busy2 = (i_rd_addr2 != '0) && (r_cnt[i_rd_addr2] != '0);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        assign o_pending_mask[r] = (r != 0) && (r_cnt[r] != '0);
    end

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : 5-stage pipeline stall controller: RAW scoreboard, stall
//               priority mux, cause FSM and saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int LAT_WIDTH      = pipe_stall_ctrl_pkg::LAT_WIDTH,
    parameter int PERF_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid_in,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr1_in,
    input  logic                      id_rd_en1_in,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr2_in,
    input  logic                      id_rd_en2_in,
    input  logic [REG_ADDR_WIDTH-1:0] id_wr_addr_in,
    input  logic                      id_wr_en_in,
    input  logic [LAT_WIDTH-1:0]      id_lat_in,
    input  logic                      ex_stall_req_in,
    input  logic                      mem_stall_req_in,
    input  logic                      flush_in,
    output logic [STALL_WIDTH-1:0]    stall_out,
    output logic                      issue_out,
    output logic                      hazard_out,
    output logic [2:0]                stall_cause_out,
    output logic [NUM_REGS-1:0]       pending_mask_out,
    output logic [PERF_WIDTH-1:0]     stall_cnt_out
);

    logic   w_busy1;
    logic   w_busy2;
    logic   w_set;
    state_e w_next;
    state_e r_state;
    logic [PERF_WIDTH-1:0] r_stall_cnt;

    reg_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_REGS       (NUM_REGS),
        .LAT_WIDTH      (LAT_WIDTH)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (flush_in),
        .i_hold         (stall_out[3]),
        .i_set          (w_set),
        .i_set_addr     (id_wr_addr_in),
        .i_set_lat      (id_lat_in),
        .i_rd_addr1     (id_rd_addr1_in),
        .i_rd_addr2     (id_rd_addr2_in),
        .o_busy1        (w_busy1),
        .o_busy2        (w_busy2),
        .o_pending_mask (pending_mask_out)
    );

    assign hazard_out = ~rst & id_valid_in &
                        ((id_rd_en1_in & w_busy1) | (id_rd_en2_in & w_busy2));

    always_comb begin
        stall_out = STALL_NONE;
        w_next    = ST_RUN;
        if (rst) begin
            stall_out = STALL_NONE;
            w_next    = ST_RUN;
        end else if (flush_in) begin
            stall_out = STALL_NONE;
            w_next    = ST_FLUSH;
        end else if (mem_stall_req_in) begin
            stall_out = STALL_MEMH;
            w_next    = ST_MEMH;
        end else if (ex_stall_req_in) begin
            stall_out = STALL_EXH;
            w_next    = ST_EXH;
        end else if (hazard_out) begin
            stall_out = STALL_HAZ;
            w_next    = ST_HAZ;
        end
    end

    assign issue_out = id_valid_in & ~stall_out[2] & ~flush_in & ~rst;
    assign w_set     = issue_out & id_wr_en_in & (id_wr_addr_in != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (stall_out[2] && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + PERF_WIDTH'(1);
            end
        end
    end

    assign stall_cause_out = r_state;
    assign stall_cnt_out   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Directed self-checking bench for pipe_stall_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid_in;
    logic [4:0]  id_rd_addr1_in;
    logic        id_rd_en1_in;
    logic [4:0]  id_rd_addr2_in;
    logic        id_rd_en2_in;
    logic [4:0]  id_wr_addr_in;
    logic        id_wr_en_in;
    logic [2:0]  id_lat_in;
    logic        ex_stall_req_in;
    logic        mem_stall_req_in;
    logic        flush_in;
    logic [5:0]  stall_out;
    logic        issue_out;
    logic        hazard_out;
    logic [2:0]  stall_cause_out;
    logic [31:0] pending_mask_out;
    logic [15:0] stall_cnt_out;

    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid_in      (id_valid_in),
        .id_rd_addr1_in   (id_rd_addr1_in),
        .id_rd_en1_in     (id_rd_en1_in),
        .id_rd_addr2_in   (id_rd_addr2_in),
        .id_rd_en2_in     (id_rd_en2_in),
        .id_wr_addr_in    (id_wr_addr_in),
        .id_wr_en_in      (id_wr_en_in),
        .id_lat_in        (id_lat_in),
        .ex_stall_req_in  (ex_stall_req_in),
        .mem_stall_req_in (mem_stall_req_in),
        .flush_in         (flush_in),
        .stall_out        (stall_out),
        .issue_out        (issue_out),
        .hazard_out       (hazard_out),
        .stall_cause_out  (stall_cause_out),
        .pending_mask_out (pending_mask_out),
        .stall_cnt_out    (stall_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid_in      = 1'b0;
        id_rd_addr1_in   = '0;
        id_rd_en1_in     = 1'b0;
        id_rd_addr2_in   = '0;
        id_rd_en2_in     = 1'b0;
        id_wr_addr_in    = '0;
        id_wr_en_in      = 1'b0;
        id_lat_in        = '0;
        ex_stall_req_in  = 1'b0;
        mem_stall_req_in = 1'b0;
        flush_in         = 1'b0;
    endtask

    task automatic writer(input logic [4:0] wa, input logic [2:0] lat);
        idle();
        id_valid_in   = 1'b1;
        id_wr_en_in   = 1'b1;
        id_wr_addr_in = wa;
        id_lat_in     = lat;
    endtask

    task automatic reader(input logic [4:0] ra);
        idle();
        id_valid_in    = 1'b1;
        id_rd_en1_in   = 1'b1;
        id_rd_addr1_in = ra;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        // Reset held: outputs gated even with requests present
        id_valid_in      = 1'b1;
        mem_stall_req_in = 1'b1;
        #1;
        chk("rst_stall", stall_out, 6'b000000);
        chk("rst_issue", issue_out, 1'b0);
        step();
        idle();
        rst = 1'b0;
        #1;
        chk("rst_cause", stall_cause_out, 3'd0);
        chk("rst_pending", pending_mask_out, 32'h0);
        chk("rst_cnt", stall_cnt_out, 16'd0);

        // 1: lat-0 writer then reader, no stall
        writer(5'd1, 3'd0);
        #1;
        chk("t1_issue_wr", issue_out, 1'b1);
        step();
        chk("t1_pending", pending_mask_out, 32'h0);
        reader(5'd1);
        #1;
        chk("t1_hazard", hazard_out, 1'b0);
        chk("t1_stall", stall_out, 6'b000000);
        chk("t1_issue_rd", issue_out, 1'b1);
        step();

        // 2: lat-2 writer then reader -> two hazard cycles
        writer(5'd2, 3'd2);
        #1;
        chk("t2_issue_wr", issue_out, 1'b1);
        step();
        chk("t2_pending", pending_mask_out, 32'h4);
        reader(5'd2);
        #1;
        chk("t2_stall_n1", stall_out, 6'b000111);
        chk("t2_hazard_n1", hazard_out, 1'b1);
        chk("t2_issue_n1", issue_out, 1'b0);
        step();
        chk("t2_cause_haz", stall_cause_out, 3'd1);
        chk("t2_stall_n2", stall_out, 6'b000111);
        step();
        chk("t2_stall_n3", stall_out, 6'b000000);
        chk("t2_issue_n3", issue_out, 1'b1);
        chk("t2_cnt", stall_cnt_out, 16'd2);
        step();
        chk("t2_cause_run", stall_cause_out, 3'd0);

        // 3: EX hold freezes the scoreboard
        writer(5'd3, 3'd2);
        step();
        reader(5'd3);
        ex_stall_req_in = 1'b1;
        #1;
        chk("t3_stall_ex", stall_out, 6'b001111);
        chk("t3_issue_ex", issue_out, 1'b0);
        step();
        chk("t3_cause_exh", stall_cause_out, 3'd2);
        chk("t3_pending", pending_mask_out, 32'h8);
        ex_stall_req_in = 1'b0;
        #1;
        chk("t3_stall_n2", stall_out, 6'b000111);
        step();
        chk("t3_stall_n3", stall_out, 6'b000111);
        step();
        chk("t3_issue_n4", issue_out, 1'b1);
        chk("t3_cnt", stall_cnt_out, 16'd5);
        step();

        // 4: r0 writes ignored, r0 reads never hazard
        writer(5'd0, 3'd3);
        step();
        chk("t4_pending", pending_mask_out, 32'h0);
        reader(5'd0);
        id_rd_en2_in = 1'b1;
        #1;
        chk("t4_stall", stall_out, 6'b000000);
        chk("t4_issue", issue_out, 1'b1);
        step();

        // 5: flush mid-hazard clears the scoreboard
        writer(5'd5, 3'd3);
        step();
        chk("t5_pending_pre", pending_mask_out, 32'h20);
        reader(5'd5);
        flush_in = 1'b1;
        #1;
        chk("t5_stall_flush", stall_out, 6'b000000);
        chk("t5_issue_flush", issue_out, 1'b0);
        step();
        chk("t5_pending_post", pending_mask_out, 32'h0);
        chk("t5_cause_flush", stall_cause_out, 3'd4);
        flush_in = 1'b0;
        #1;
        chk("t5_hazard_after", hazard_out, 1'b0);
        chk("t5_issue_after", issue_out, 1'b1);
        step();

        // 6: MEM over EX priority, then reset mid-stall
        writer(5'd6, 3'd3);
        step();
        idle();
        mem_stall_req_in = 1'b1;
        ex_stall_req_in  = 1'b1;
        #1;
        chk("t6_stall_mem", stall_out, 6'b011111);
        step();
        chk("t6_cause_memh", stall_cause_out, 3'd3);
        chk("t6_pending_held", pending_mask_out, 32'h40);
        chk("t6_cnt_pre", stall_cnt_out, 16'd6);
        rst = 1'b1;
        id_valid_in    = 1'b1;
        id_rd_en1_in   = 1'b1;
        id_rd_addr1_in = 5'd6;
        #1;
        chk("t6_stall_rst", stall_out, 6'b000000);
        chk("t6_hazard_rst", hazard_out, 1'b0);
        chk("t6_issue_rst", issue_out, 1'b0);
        step();
        rst = 1'b0;
        idle();
        chk("t6_pending_rst", pending_mask_out, 32'h0);
        chk("t6_cause_rst", stall_cause_out, 3'd0);
        chk("t6_cnt_rst", stall_cnt_out, 16'd0);
        reader(5'd6);
        #1;
        chk("t6_stall_after", stall_out, 6'b000000);
        step();

        // Saturation of the stall-cycle counter
        idle();
        mem_stall_req_in = 1'b1;
        repeat (65539) step();
        chk("sat_cnt", stall_cnt_out, 16'hFFFF);
        idle();
        step();
        chk("sat_hold", stall_cnt_out, 16'hFFFF);
        chk("sat_cause_run", stall_cause_out, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
